mem_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port instruction/data memory in the combined processor-plus-memory top level. It shares the memory between the `mips` core (port C) and a debug/loader requester (port D), and it stalls the core while an access is pending or while the debug port owns the memory. All memory-side outputs are registered. Ties between the two ports are resolved round-robin.

---
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter.sv | 74 +++++++
 tb/tb_mem_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: core, debug-loader and memory-side signals of the shared memory arbiter.
// master is the surrounding system (core, loader, memory); slave is the arbiter itself.
interface mem_arbiter_if #(parameter int AW = 8, parameter int DW = 8);
    logic          cpu_read;
    logic          cpu_write;
    logic [AW-1:0] cpu_adr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_stall;
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_adr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_ack;
    logic [DW-1:0] dbg_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_adr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        output cpu_read, cpu_write, cpu_adr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output dbg_req, dbg_we, dbg_adr, dbg_wdata,
        input  dbg_ack, dbg_rdata,
        input  mem_en, mem_we, mem_adr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  cpu_read, cpu_write, cpu_adr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  dbg_req, dbg_we, dbg_adr, dbg_wdata,
        output dbg_ack, dbg_rdata,
        output mem_en, mem_we, mem_adr, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one memory port between the core (C) and the debug loader (D).
// Memory-side outputs are registered; the core stalls until its own access reaches DONE.
module mem_arbiter #(
    parameter int AW      = 8,
    parameter int DW      = 8,
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    mem_arbiter_if.slave bus
);
    localparam int CW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state, state_n;
    logic          req_c, gnt, gnt_d, last_beat;
    logic          owner, last_gnt, cpu_done;
    logic [CW-1:0] cnt;

    assign req_c         = bus.cpu_read | bus.cpu_write;
    assign bus.cpu_stall = req_c & ~(cpu_done & ~reset);

    // last_gnt/owner: 1 means port D; a tie goes to the port that did not win last time
    always_comb begin
        state_n   = state;
        gnt       = 1'b0;
        gnt_d     = bus.dbg_req & (~req_c | ~last_gnt);
        last_beat = cnt == CW'(MEM_LAT - 1);
        unique case (state)
            IDLE: begin
                gnt     = req_c | bus.dbg_req;
                state_n = gnt ? ISSUE : IDLE;
            end
            ISSUE:   state_n = bus.mem_we ? DONE : WAIT;
            WAIT:    state_n = last_beat ? DONE : WAIT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            owner         <= 1'b0;
            last_gnt      <= 1'b1;
            cnt           <= '0;
            cpu_done      <= 1'b0;
            bus.dbg_ack   <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_adr   <= '0;
            bus.mem_wdata <= '0;
            bus.cpu_rdata <= '0;
            bus.dbg_rdata <= '0;
        end else begin
            state       <= state_n;
            cnt         <= state == WAIT ? cnt + 1'b1 : '0;
            bus.mem_en  <= gnt;
            bus.mem_we  <= gnt & (gnt_d ? bus.dbg_we : bus.cpu_write);
            cpu_done    <= (state_n == DONE) & ~owner;
            bus.dbg_ack <= (state_n == DONE) & owner;
            if (gnt) begin
                owner         <= gnt_d;
                last_gnt      <= gnt_d;
                bus.mem_adr   <= gnt_d ? bus.dbg_adr : bus.cpu_adr;
                bus.mem_wdata <= gnt_d ? bus.dbg_wdata : bus.cpu_wdata;
            end
            if (state == WAIT && last_beat) begin
                if (owner) bus.dbg_rdata <= bus.mem_rdata;
                else       bus.cpu_rdata <= bus.mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural memory of latency LAT.
// Expected completions are queued per port when a request is driven and checked when it completes.
module tb_mem_arbiter;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int LAT = 1;

    typedef struct {
        bit            rd;
        logic [DW-1:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus();

    mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    logic [DW-1:0] mem [256];
    logic [DW-1:0] pipe [LAT];

    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_we) mem[bus.mem_adr] <= bus.mem_wdata;
        pipe[0] <= mem[bus.mem_adr];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bus.mem_rdata = pipe[LAT-1];

    int n_tests = 0;
    int n_fail  = 0;
    int n_en    = 0;
    exp_t cq[$];
    exp_t dq[$];
    bit   ord[$];
    logic [DW-1:0] cpu_m = '0;
    logic [DW-1:0] dbg_m = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // completion monitor: pops the scoreboard and tracks the expected rdata registers
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (bus.mem_en) n_en++;
            if ((bus.cpu_read || bus.cpu_write) && !bus.cpu_stall) begin
                ord.push_back(1'b0);
                if (cq.size() == 0) chk("cpu_unexpected_done", 1, 0);
                else begin
                    e = cq.pop_front();
                    if (e.rd) cpu_m = e.d;
                end
            end
            if (bus.dbg_ack) begin
                ord.push_back(1'b1);
                if (dq.size() == 0) chk("dbg_unexpected_ack", 1, 0);
                else begin
                    e = dq.pop_front();
                    if (e.rd) dbg_m = e.d;
                end
            end
            chk("cpu_rdata", bus.cpu_rdata, cpu_m);
            chk("dbg_rdata", bus.dbg_rdata, dbg_m);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_acc(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input logic [DW-1:0] rd);
        bit ok = 1'b0;
        cq.push_back('{!wr, rd});
        bus.cpu_read  = 1'b1;
        bus.cpu_write = wr;
        bus.cpu_adr   = a;
        bus.cpu_wdata = wd;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = !bus.cpu_stall;
        end
        chk("cpu_acc_done", ok, 1);
        cyc();
        bus.cpu_read  = 1'b0;
        bus.cpu_write = 1'b0;
    endtask

    task automatic dbg_acc(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input logic [DW-1:0] rd);
        bit ok = 1'b0;
        dq.push_back('{!we, rd});
        bus.dbg_req   = 1'b1;
        bus.dbg_we    = we;
        bus.dbg_adr   = a;
        bus.dbg_wdata = wd;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = bus.dbg_ack;
        end
        chk("dbg_acc_ack", ok, 1);
        cyc();
        bus.dbg_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hC3;
        mem[8'h10] = 8'hA5;
        bus.cpu_read  = 1'b1;
        bus.cpu_write = 1'b0;
        bus.cpu_adr   = 8'h10;
        bus.cpu_wdata = '0;
        bus.dbg_req   = 1'b0;
        bus.dbg_we    = 1'b0;
        bus.dbg_adr   = '0;
        bus.dbg_wdata = '0;

        // reset held two cycles with a core read pending, then the read itself
        cyc();
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_cpu_rdata", bus.cpu_rdata, 0);
        chk("rst_dbg_rdata", bus.dbg_rdata, 0);
        chk("rst_dbg_ack", bus.dbg_ack, 0);
        chk("rst_stall", bus.cpu_stall, 1);
        cyc();
        reset = 1'b0;
        cq.push_back('{1'b1, 8'hA5});
        chk("rd_c0_stall", bus.cpu_stall, 1);
        chk("rd_c0_en", bus.mem_en, 0);
        cyc();
        chk("rd_c1_en", bus.mem_en, 1);
        chk("rd_c1_we", bus.mem_we, 0);
        chk("rd_c1_adr", bus.mem_adr, 8'h10);
        chk("rd_c1_stall", bus.cpu_stall, 1);
        cyc();
        chk("rd_c2_en", bus.mem_en, 0);
        chk("rd_c2_stall", bus.cpu_stall, 1);
        cyc();
        chk("rd_c3_stall", bus.cpu_stall, 0);
        chk("rd_c3_data", bus.cpu_rdata, 8'hA5);
        cyc();
        bus.cpu_read = 1'b0;

        // debug write then core read of the same location
        dq.push_back('{1'b0, 8'h00});
        bus.dbg_req   = 1'b1;
        bus.dbg_we    = 1'b1;
        bus.dbg_adr   = 8'h20;
        bus.dbg_wdata = 8'h3C;
        cyc();
        chk("dw_c1_en", bus.mem_en, 1);
        chk("dw_c1_we", bus.mem_we, 1);
        chk("dw_c1_adr", bus.mem_adr, 8'h20);
        chk("dw_c1_wdata", bus.mem_wdata, 8'h3C);
        chk("dw_c1_ack", bus.dbg_ack, 0);
        cyc();
        chk("dw_c2_ack", bus.dbg_ack, 1);
        cyc();
        bus.dbg_req = 1'b0;
        chk("dw_c3_ack", bus.dbg_ack, 0);
        cpu_acc(1'b0, 8'h20, 8'h00, 8'h3C);

        // both ports requesting continuously out of reset
        reset = 1'b1;
        cq.delete();
        dq.delete();
        cpu_m = '0;
        dbg_m = '0;
        bus.cpu_read = 1'b1;
        bus.cpu_adr  = 8'h40;
        bus.dbg_req  = 1'b1;
        bus.dbg_we   = 1'b0;
        bus.dbg_adr  = 8'h41;
        cyc();
        cyc();
        reset = 1'b0;
        ord.delete();
        repeat (2) cq.push_back('{1'b1, 8'h40 ^ 8'hC3});
        repeat (2) dq.push_back('{1'b1, 8'h41 ^ 8'hC3});
        for (int i = 0; i < 60 && ord.size() < 4; i++) begin
            @(negedge clk);
            #1;
        end
        cyc();
        bus.cpu_read = 1'b0;
        bus.dbg_req  = 1'b0;
        chk("rr_count", ord.size(), 4);
        for (int i = 0; i < 4 && i < ord.size(); i++) chk("rr_order", ord[i], i % 2);

        // reset during the WAIT cycle of a debug read
        cyc();
        bus.dbg_req = 1'b1;
        bus.dbg_we  = 1'b0;
        bus.dbg_adr = 8'h05;
        cyc();
        chk("rmr_c1_en", bus.mem_en, 1);
        chk("rmr_c1_adr", bus.mem_adr, 8'h05);
        cyc();
        reset = 1'b1;
        bus.dbg_req = 1'b0;
        dq.delete();
        cq.delete();
        cpu_m = '0;
        dbg_m = '0;
        cyc();
        reset = 1'b0;
        repeat (3) begin
            cyc();
            chk("rmr_no_ack", bus.dbg_ack, 0);
        end
        chk("rmr_dbg_rdata", bus.dbg_rdata, 0);
        dbg_acc(1'b0, 8'h05, 8'h00, 8'h05 ^ 8'hC3);

        // debug write withdrawn during ISSUE still completes once
        e0 = n_en;
        dq.push_back('{1'b0, 8'h00});
        bus.dbg_req   = 1'b1;
        bus.dbg_we    = 1'b1;
        bus.dbg_adr   = 8'h30;
        bus.dbg_wdata = 8'h77;
        cyc();
        chk("ew_c1_en", bus.mem_en, 1);
        chk("ew_c1_we", bus.mem_we, 1);
        bus.dbg_req = 1'b0;
        cyc();
        chk("ew_c2_ack", bus.dbg_ack, 1);
        repeat (4) cyc();
        chk("ew_one_grant", n_en - e0, 1);
        chk("ew_mem", mem[8'h30], 8'h77);

        // core write (read+write together means write) observed by a debug read
        cpu_acc(1'b1, 8'h50, 8'h99, 8'h00);
        chk("cw_mem", mem[8'h50], 8'h99);
        dbg_acc(1'b0, 8'h50, 8'h00, 8'h99);
        repeat (3) cyc();

        chk("cq_drained", cq.size(), 0);
        chk("dq_drained", dq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
